muldiv_sequencer: RTL

Multi-cycle controller for the execute stage's multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU requests from EX and runs one shift-add or restoring-divide iteration per clock. While the operation is in flight it stalls the pipeline, then writes the HI/LO result registers. It sits beside the EX ALU, and its HI/LO outputs feed the MFHI/MFLO path.

---
 rtl/muldiv_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               b_zero;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_orig;
  logic [2*WIDTH-1:0] acc;

  logic               sgn_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    sgn_op   = ~op[0];
    a_neg    = sgn_op & operand_a[WIDTH-1];
    b_neg    = sgn_op & operand_b[WIDTH-1];
    mag_a_in = a_neg ? -operand_a : operand_a;
    mag_b_in = b_neg ? -operand_b : operand_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    // Divide: acc = {remainder, quotient}; a borrow out of div_diff means restore.
    div_tmp  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_tmp - {1'b0, mag_b};

    if (is_div) begin
      if (div_diff[WIDTH]) begin
        acc_next = {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end

    product = neg_res ? -acc_next : acc_next;
    quo     = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem     = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
  end

  assign stall = ((state == IDLE) & start) | (state == RUN);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      b_zero      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      a_orig      <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            is_div  <= op[1];
            b_zero  <= (operand_b == '0);
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            mag_a   <= mag_a_in;
            mag_b   <= mag_b_in;
            a_orig  <= operand_a;
            acc     <= op[1] ? {{WIDTH{1'b0}}, mag_a_in} : {{WIDTH{1'b0}}, mag_b_in};
            count   <= CW'(WIDTH - 1);
            state   <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            count <= count - 1'b1;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
              if (is_div && b_zero) begin
                hi          <= a_orig;
                lo          <= '1;
                div_by_zero <= 1'b1;
              end else if (is_div) begin
                hi <= rem;
                lo <= quo;
              end else begin
                hi <= product[2*WIDTH-1:WIDTH];
                lo <= product[WIDTH-1:0];
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
